inst_fetch_responder: RTL and testbench

- Instruction-side responder answering the control unit's FETCH-state request; produces the `inst_ack` pulse the control unit waits on.
- Latches the PC, issues one read to the instruction memory, and waits a variable latency for the data.
- Returns the instruction word plus pre-extracted `op` and `func` fields.
- Handles flush (drains the stale read) and memory timeout (fault).

---
 rtl/inst_fetch_responder_if.sv | 30 +++
 rtl/inst_fetch_responder.sv | 119 +++++++++++
 tb/tb_inst_fetch_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_responder_if.sv
// Bundle between the control unit, the fetch responder and the instruction memory.
// The slave modport is the responder's view; master is the driver side (control unit + memory).
interface inst_fetch_responder_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    logic          fetch_req_i;
    logic [AW-1:0] pc_i;
    logic          flush_i;
    logic          inst_ack_o;
    logic [IW-1:0] inst_o;
    logic [2:0]    op_o;
    logic [2:0]    func_o;
    logic          fault_o;
    logic          busy_o;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [IW-1:0] mem_rdata_i;
    logic          mem_valid_i;

    modport slave (
        input  fetch_req_i, pc_i, flush_i, mem_rdata_i, mem_valid_i,
        output inst_ack_o, inst_o, op_o, func_o, fault_o, busy_o, mem_rd_o, mem_addr_o
    );

    modport master (
        output fetch_req_i, pc_i, flush_i, mem_rdata_i, mem_valid_i,
        input  inst_ack_o, inst_o, op_o, func_o, fault_o, busy_o, mem_rd_o, mem_addr_o
    );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: latches the PC, issues one memory read, waits for data
// (with flush drain and timeout fault) and acknowledges the control unit with a one-cycle pulse.
module inst_fetch_responder #(
    parameter int AW      = 8,
    parameter int IW      = 16,
    parameter int TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst,
    inst_fetch_responder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_DRAIN
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic [AW-1:0] r_memAddr;
    logic          r_memRd;
    logic [IW-1:0] r_inst;
    logic [2:0]    r_op;
    logic [2:0]    r_func;
    logic          r_ack;
    logic          r_fault;
    logic          r_busy;
    logic [7:0]    w_cntNext;

    assign w_cntNext = r_cnt + 8'd1;

    // Counter measures cycles since the strobe; timeout fires when the cycle being left reaches TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_memAddr <= '0;
            r_memRd   <= 1'b0;
            r_inst    <= '0;
            r_op      <= 3'd0;
            r_func    <= 3'd0;
            r_ack     <= 1'b0;
            r_fault   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_memRd <= 1'b0;
            r_ack   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.fetch_req_i) begin
                        r_memAddr <= bus.pc_i;
                        r_memRd   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt   <= 8'd0;
                    r_state <= bus.flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= w_cntNext;
                    // A flush in the same cycle as the data beats the data.
                    if (bus.mem_valid_i && bus.flush_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.mem_valid_i) begin
                        r_inst  <= bus.mem_rdata_i;
                        r_op    <= bus.mem_rdata_i[IW-1:IW-3];
                        r_func  <= bus.mem_rdata_i[2:0];
                        r_fault <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (bus.flush_i) begin
                        r_state <= S_DRAIN;
                    end else if (w_cntNext >= TO) begin
                        r_inst  <= '0;
                        r_op    <= 3'd0;
                        r_func  <= 3'd0;
                        r_fault <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_fault <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    r_cnt <= w_cntNext;
                    if (bus.mem_valid_i || (w_cntNext >= TO)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.inst_ack_o = r_ack;
    assign bus.inst_o     = r_inst;
    assign bus.op_o       = r_op;
    assign bus.func_o     = r_func;
    assign bus.fault_o    = r_fault;
    assign bus.busy_o     = r_busy;
    assign bus.mem_rd_o   = r_memRd;
    assign bus.mem_addr_o = r_memAddr;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: a scoreboard queue holds the expected ack
// payloads, popped by a monitor whenever the responder acknowledges.
module tb_inst_fetch_responder;

    typedef struct {
        logic [15:0] inst;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFail = 0;
    int   cycle = 0;
    int   ackCount = 0;
    int   ackTimes[$];
    exp_t expQ[$];
    exp_t monE;
    logic [15:0] lastInst = 16'h0;
    int   idx0;

    inst_fetch_responder_if #(.AW(8), .IW(16)) bus ();

    inst_fetch_responder #(.AW(8), .IW(16), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [7:0] pc, input logic flush,
                                 input logic valid, input logic [15:0] rdata);
        bus.fetch_req_i = req;
        bus.pc_i        = pc;
        bus.flush_i     = flush;
        bus.mem_valid_i = valid;
        bus.mem_rdata_i = rdata;
    endtask

    // Raise the request and wait (bounded) for the read strobe.
    task automatic waitStrobe(input logic [7:0] pc);
        bit seen;
        seen = 1'b0;
        bus.fetch_req_i = 1'b1;
        bus.pc_i        = pc;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.mem_rd_o === 1'b1) seen = 1'b1;
        end
        checkOutput("strobe_seen", {31'b0, seen}, 32'd1);
        checkOutput("strobe_addr", {24'b0, bus.mem_addr_o}, {24'b0, pc});
        checkOutput("busy_in_req", {31'b0, bus.busy_o}, 32'd1);
    endtask

    task automatic doFetch(input logic [7:0] pc, input logic [15:0] data, input int lat, input bit holdReq);
        waitStrobe(pc);
        if (!holdReq) bus.fetch_req_i = 1'b0;
        expQ.push_back('{data, 1'b0});
        for (int i = 0; i < lat; i++) begin
            tick();
            if (i == 0) checkOutput("strobe_one_cycle", {31'b0, bus.mem_rd_o}, 32'd0);
        end
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = data;
        tick();
        bus.mem_valid_i = 1'b0;
        bus.mem_rdata_i = 16'h0;
        checkOutput("ack_pulse", {31'b0, bus.inst_ack_o}, 32'd1);
        lastInst = data;
    endtask

    // Scoreboard consumer: every ack must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.inst_ack_o === 1'b1) begin
            ackCount++;
            ackTimes.push_back(cycle);
            checkOutput("ack_has_expected", {31'b0, expQ.size() != 0}, 32'd1);
            if (expQ.size() != 0) begin
                monE = expQ.pop_front();
                checkOutput("ack_inst", {16'b0, bus.inst_o}, {16'b0, monE.inst});
                checkOutput("ack_op", {29'b0, bus.op_o}, {29'b0, monE.inst[15:13]});
                checkOutput("ack_func", {29'b0, bus.func_o}, {29'b0, monE.inst[2:0]});
                checkOutput("ack_fault", {31'b0, bus.fault_o}, {31'b0, monE.fault});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
        tick();
        tick();
        checkOutput("rst_inst", {16'b0, bus.inst_o}, 32'd0);
        checkOutput("rst_ack", {31'b0, bus.inst_ack_o}, 32'd0);
        checkOutput("rst_busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("rst_memrd", {31'b0, bus.mem_rd_o}, 32'd0);
        checkOutput("rst_addr", {24'b0, bus.mem_addr_o}, 32'd0);
        checkOutput("rst_fault", {31'b0, bus.fault_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic fetch, memory latency 2.
        doFetch(8'h10, 16'hA5C3, 2, 1'b0);
        checkOutput("basic_op", {29'b0, bus.op_o}, 32'd5);
        checkOutput("basic_func", {29'b0, bus.func_o}, 32'd3);
        tick();
        checkOutput("basic_ack_one_cycle", {31'b0, bus.inst_ack_o}, 32'd0);
        checkOutput("basic_idle_busy", {31'b0, bus.busy_o}, 32'd0);

        // Back-to-back with request held, latency 1.
        idx0 = ackTimes.size();
        doFetch(8'h00, 16'h1001, 1, 1'b1);
        doFetch(8'h01, 16'h2012, 1, 1'b1);
        doFetch(8'h02, 16'h3023, 1, 1'b1);
        bus.fetch_req_i = 1'b0;
        tick();
        checkOutput("b2b_ack_num", 32'(ackTimes.size() - idx0), 32'd3);
        if (ackTimes.size() >= idx0 + 3) begin
            checkOutput("b2b_spacing_1", 32'(ackTimes[idx0+1] - ackTimes[idx0]), 32'd4);
            checkOutput("b2b_spacing_2", 32'(ackTimes[idx0+2] - ackTimes[idx0+1]), 32'd4);
        end

        // Memory never answers: fault ack after 15 WAIT cycles.
        waitStrobe(8'h20);
        bus.fetch_req_i = 1'b0;
        expQ.push_back('{16'h0000, 1'b1});
        repeat (15) tick();
        checkOutput("to_no_early_ack", {31'b0, bus.inst_ack_o}, 32'd0);
        tick();
        checkOutput("to_ack", {31'b0, bus.inst_ack_o}, 32'd1);
        checkOutput("to_fault", {31'b0, bus.fault_o}, 32'd1);
        checkOutput("to_inst_zero", {16'b0, bus.inst_o}, 32'd0);
        lastInst = 16'h0000;
        tick();
        checkOutput("to_fault_clears", {31'b0, bus.fault_o}, 32'd0);
        doFetch(8'h21, 16'h1234, 3, 1'b0);
        tick();

        // Flush one cycle after the strobe, data arrives later and is drained.
        waitStrobe(8'h30);
        bus.fetch_req_i = 1'b0;
        tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("drain_busy", {31'b0, bus.busy_o}, 32'd1);
        tick();
        tick();
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 16'hDEAD;
        tick();
        bus.mem_valid_i = 1'b0;
        bus.mem_rdata_i = 16'h0;
        checkOutput("drain_idle", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("drain_no_ack", {31'b0, bus.inst_ack_o}, 32'd0);
        checkOutput("drain_inst_kept", {16'b0, bus.inst_o}, {16'b0, lastInst});
        doFetch(8'h31, 16'h4321, 1, 1'b0);
        tick();

        // Flush and valid together in WAIT: data dropped, straight to IDLE.
        waitStrobe(8'h40);
        bus.fetch_req_i = 1'b0;
        tick();
        applyStimulus(1'b0, 8'h40, 1'b1, 1'b1, 16'hBEEF);
        tick();
        applyStimulus(1'b0, 8'h40, 1'b0, 1'b0, 16'h0);
        checkOutput("fv_idle", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("fv_no_ack", {31'b0, bus.inst_ack_o}, 32'd0);
        checkOutput("fv_inst_kept", {16'b0, bus.inst_o}, {16'b0, lastInst});
        tick();
        checkOutput("fv_no_late_ack", {31'b0, bus.inst_ack_o}, 32'd0);

        // Spurious valid while idle.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 16'h7777);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
        checkOutput("spur_idle", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("spur_no_rd", {31'b0, bus.mem_rd_o}, 32'd0);
        tick();
        checkOutput("spur_no_ack", {31'b0, bus.inst_ack_o}, 32'd0);
        checkOutput("spur_inst_kept", {16'b0, bus.inst_o}, {16'b0, lastInst});

        // Asynchronous reset in the middle of WAIT.
        waitStrobe(8'h50);
        bus.fetch_req_i = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_inst", {16'b0, bus.inst_o}, 32'd0);
        checkOutput("arst_busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("arst_addr", {24'b0, bus.mem_addr_o}, 32'd0);
        checkOutput("arst_op", {29'b0, bus.op_o}, 32'd0);
        checkOutput("arst_func", {29'b0, bus.func_o}, 32'd0);
        lastInst = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 16'h9999);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
        checkOutput("arst_late_valid_busy", {31'b0, bus.busy_o}, 32'd0);
        tick();
        checkOutput("arst_late_valid_ack", {31'b0, bus.inst_ack_o}, 32'd0);

        doFetch(8'h60, 16'h0F0F, 2, 1'b0);
        tick();
        tick();

        checkOutput("total_acks", 32'(ackCount), 32'd8);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
